mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 28 ++
 rtl/mem_responder_array.sv | 32 +++
 rtl/mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_mem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: state encoding, latency bounds
// and the even-parity helper used when MEM_PARITY_EN is defined.
package mem_responder_pkg;

    localparam logic [1:0] IDLE_ENC   = 2'd0;
    localparam logic [1:0] SEL_ENC    = 2'd1;
    localparam logic [1:0] ACCESS_ENC = 2'd2;
    localparam logic [1:0] READY_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE_ENC,
        ST_SEL    = SEL_ENC,
        ST_ACCESS = ACCESS_ENC,
        ST_READY  = READY_ENC
    } state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int PAR_MAX_W   = 64;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word array for the responder: synchronous write, combinational read.
// Out-of-range writes are dropped and out-of-range reads return zero.
module mem_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_in_range;
    logic             rd_in_range;

    assign wr_in_range = int'(wr_addr) < DEPTH;
    assign rd_in_range = int'(rd_addr) < DEPTH;

    // NOTE: storage has no reset; contents are defined only by preload writes.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_in_range ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency read responder paired with device_controller.
// Optional MEM_PARITY_EN adds a stored even-parity bit and a mem_parity output.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int size    = 16,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int LATENCY = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs_n,
    input  logic            rd,
    input  logic            dregen,
    input  logic [AW-1:0]   rd_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [size-1:0] wr_data,
    output logic            mem_ready,
    output logic [size-1:0] mem_data,
    output logic            mem_busy,
    output logic            mem_err
`ifdef MEM_PARITY_EN
    ,
    output logic            mem_parity
`endif
);

    // Out-of-range LATENCY values clamp to the nearest legal bound.
    localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                             (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

`ifdef MEM_PARITY_EN
    localparam int WORD_W = size + 1;
`else
    localparam int WORD_W = size;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              ready_q, ready_d;
    logic [size-1:0]   data_q, data_d;
    logic              err_q, err_d;
    logic              was_ready_q, was_ready_d;

    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic [size-1:0]   rd_word;
    logic              addr_ok;
    logic              dregen_ok;

`ifdef MEM_PARITY_EN
    logic                 parity_q, parity_d;
    logic [PAR_MAX_W-1:0] wr_ext;
    logic [PAR_MAX_W-1:0] rd_ext;
    logic                 rd_par;
    logic                 par_bad;

    always_comb begin
        wr_ext            = '0;
        wr_ext[size-1:0]  = wr_data;
        arr_wdata         = {even_parity(wr_ext), wr_data};
    end

    always_comb begin
        rd_ext           = '0;
        rd_ext[size-1:0] = arr_rdata[size-1:0];
        rd_par           = arr_rdata[size];
        par_bad          = rd_par != even_parity(rd_ext);
    end

    assign mem_parity = parity_q;
`else
    assign arr_wdata = wr_data;
`endif

    mem_array #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (arr_wdata),
        .rd_addr (addr_q),
        .rd_data (arr_rdata)
    );

    assign rd_word   = arr_rdata[size-1:0];
    assign addr_ok   = int'(addr_q) < DEPTH;
    // The controller may still hold dregen for one cycle after READY exits.
    assign dregen_ok = (state_q == ST_READY) || ((state_q == ST_IDLE) && was_ready_q);

    // NOTE: every next-state value takes its hold value first, so no latches form.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ready_d     = ready_q;
        data_d      = data_q;
        err_d       = err_q;
        was_ready_d = (state_q == ST_READY);
`ifdef MEM_PARITY_EN
        parity_d    = parity_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (!cs_n) begin
                    addr_d  = rd_addr;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (rd) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_ACCESS: begin
                if (cs_n || !rd) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                    data_d  = rd_word;
                    if (!addr_ok) begin
                        err_d = 1'b1;
                    end
`ifdef MEM_PARITY_EN
                    parity_d = rd_par;
                    if (addr_ok && par_bad) begin
                        err_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_READY: begin
                if (!rd) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd && cs_n) begin
            err_d = 1'b1;
        end
        if (dregen && !dregen_ok) begin
            err_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            ready_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            was_ready_q <= 1'b0;
`ifdef MEM_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            err_q       <= err_d;
            was_ready_q <= was_ready_d;
`ifdef MEM_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign mem_ready = ready_q;
    assign mem_data  = data_q;
    assign mem_err   = err_q;
    assign mem_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: unit 0 runs LATENCY=3, unit 1 runs LATENCY=1.
// Read expectations are queued at issue time and checked by per-unit monitors.
module tb_mem_responder;

    typedef struct {
        int          unit;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cs_n_s     [2];
    logic        rd_s       [2];
    logic        dregen_s   [2];
    logic [3:0]  rd_addr_s  [2];
    logic        wr_en_s    [2];
    logic [3:0]  wr_addr_s  [2];
    logic [15:0] wr_data_s  [2];
    logic        ready_w    [2];
    logic [15:0] data_w     [2];
    logic        busy_w     [2];
    logic        err_w      [2];
`ifdef MEM_PARITY_EN
    logic        par_w      [2];
`endif

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.size(16), .DEPTH(16), .AW(4), .LATENCY(3)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n_s[0]),
        .rd        (rd_s[0]),
        .dregen    (dregen_s[0]),
        .rd_addr   (rd_addr_s[0]),
        .wr_en     (wr_en_s[0]),
        .wr_addr   (wr_addr_s[0]),
        .wr_data   (wr_data_s[0]),
        .mem_ready (ready_w[0]),
        .mem_data  (data_w[0]),
        .mem_busy  (busy_w[0]),
        .mem_err   (err_w[0])
`ifdef MEM_PARITY_EN
        ,
        .mem_parity(par_w[0])
`endif
    );

    mem_responder #(.size(16), .DEPTH(16), .AW(4), .LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n_s[1]),
        .rd        (rd_s[1]),
        .dregen    (dregen_s[1]),
        .rd_addr   (rd_addr_s[1]),
        .wr_en     (wr_en_s[1]),
        .wr_addr   (wr_addr_s[1]),
        .wr_data   (wr_data_s[1]),
        .mem_ready (ready_w[1]),
        .mem_data  (data_w[1]),
        .mem_busy  (busy_w[1]),
        .mem_err   (err_w[1])
`ifdef MEM_PARITY_EN
        ,
        .mem_parity(par_w[1])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitors: compare each mem_ready rise against the queue and check pulse width.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic prev_rdy;
        int   hi_cnt;
        initial begin
            prev_rdy = 1'b0;
            hi_cnt   = 0;
        end
        always @(negedge clk) begin
            exp_t e;
            if (ready_w[g] === 1'b1 && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_ready_u%0d", g), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sb_unit_u%0d", g), g, e.unit);
                    check($sformatf("sb_data_u%0d", g), {16'h0, data_w[g]}, {16'h0, e.data});
                end
            end
            if (ready_w[g] === 1'b1) begin
                hi_cnt++;
            end else if (prev_rdy) begin
                check($sformatf("ready_width_u%0d", g), hi_cnt, 2);
                hi_cnt = 0;
            end
            prev_rdy = (ready_w[g] === 1'b1);
        end
    end

    task automatic wr_word(input int u, input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        wr_en_s[u]   = 1'b1;
        wr_addr_s[u] = addr;
        wr_data_s[u] = data;
        @(negedge clk);
        wr_en_s[u]   = 1'b0;
    endtask

    // device_controller-style read; optionally writes coll_data to addr on the array-read edge.
    task automatic ctrl_read(input int u, input logic [3:0] addr, input int lat,
                             input logic [15:0] exp_data, input bit exp_err,
                             input bit coll, input logic [15:0] coll_data);
        int   k;
        exp_t e;
        e.unit = u;
        e.data = exp_data;
        exp_q.push_back(e);
        @(negedge clk);
        cs_n_s[u]    = 1'b0;
        rd_addr_s[u] = addr;
        @(negedge clk);
        rd_s[u] = 1'b1;
        k = 0;
        while (1) begin
            @(negedge clk);
            k++;
            wr_en_s[u] = 1'b0;
            if (ready_w[u] === 1'b1) break;
            if (k > 20) break;
            if (coll && k == lat) begin
                wr_en_s[u]   = 1'b1;
                wr_addr_s[u] = addr;
                wr_data_s[u] = coll_data;
            end
        end
        check($sformatf("latency_u%0d", u), k - 1, lat);
        @(negedge clk);
        rd_s[u]     = 1'b0;
        dregen_s[u] = 1'b1;
        cs_n_s[u]   = 1'b1;
        @(negedge clk);
        dregen_s[u] = 1'b0;
        check($sformatf("ready_low_after_u%0d", u), {31'h0, ready_w[u]}, 32'd0);
        check($sformatf("busy_low_after_u%0d", u), {31'h0, busy_w[u]}, 32'd0);
        check($sformatf("err_after_read_u%0d", u), {31'h0, err_w[u]}, {31'h0, exp_err});
    endtask

    task automatic check_idle_zero(input int u, input string tag);
        check({tag, "_ready"}, {31'h0, ready_w[u]}, 32'd0);
        check({tag, "_data"},  {16'h0, data_w[u]},  32'd0);
        check({tag, "_busy"},  {31'h0, busy_w[u]},  32'd0);
        check({tag, "_err"},   {31'h0, err_w[u]},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            cs_n_s[u]    = 1'b1;
            rd_s[u]      = 1'b0;
            dregen_s[u]  = 1'b0;
            rd_addr_s[u] = '0;
            wr_en_s[u]   = 1'b0;
            wr_addr_s[u] = '0;
            wr_data_s[u] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_zero(0, "reset_u0");
        check_idle_zero(1, "reset_u1");
        rst = 1'b0;

        wr_word(0, 4'd5,  16'hA5A5);
        wr_word(0, 4'd3,  16'h0BAD);
        wr_word(1, 4'd0,  16'h0001);
        wr_word(1, 4'd15, 16'hFFFF);

        // Basic read, LATENCY=3.
        ctrl_read(0, 4'd5, 3, 16'hA5A5, 1'b0, 1'b0, 16'h0);
        check("hold_data_u0", {16'h0, data_w[0]}, 32'h0000A5A5);

        // Write colliding with the array-read edge returns the old word.
        ctrl_read(0, 4'd3, 3, 16'h0BAD, 1'b0, 1'b1, 16'h1234);
        ctrl_read(0, 4'd3, 3, 16'h1234, 1'b0, 1'b0, 16'h0);

        // Back-to-back reads, LATENCY=1.
        ctrl_read(1, 4'd0, 1, 16'h0001, 1'b0, 1'b0, 16'h0);
        check("hold_between_u1", {16'h0, data_w[1]}, 32'h00000001);
        ctrl_read(1, 4'd15, 1, 16'hFFFF, 1'b0, 1'b0, 16'h0);

        // rd high with cs_n high is a protocol error.
        @(negedge clk);
        rd_s[1] = 1'b1;
        @(negedge clk);
        rd_s[1] = 1'b0;
        check("proto_rd_no_cs_err_u1", {31'h0, err_w[1]}, 32'd1);

        // Abort by raising cs_n during ACCESS.
        @(negedge clk);
        cs_n_s[0]    = 1'b0;
        rd_addr_s[0] = 4'd5;
        @(negedge clk);
        rd_s[0] = 1'b1;
        @(negedge clk);
        check("abort_in_access_busy", {31'h0, busy_w[0]}, 32'd1);
        cs_n_s[0] = 1'b1;
        rd_s[0]   = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'h0, busy_w[0]}, 32'd0);
        check("abort_ready", {31'h0, ready_w[0]}, 32'd0);
        check("abort_err", {31'h0, err_w[0]}, 32'd1);
        check("abort_data_held", {16'h0, data_w[0]}, 32'h00001234);
        repeat (4) @(negedge clk);
        check("abort_err_sticky", {31'h0, err_w[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clears_err", {31'h0, err_w[0]}, 32'd0);
        rst = 1'b0;

        // Reset during ACCESS.
        @(negedge clk);
        cs_n_s[0]    = 1'b0;
        rd_addr_s[0] = 4'd5;
        @(negedge clk);
        rd_s[0] = 1'b1;
        @(negedge clk);
        rst       = 1'b1;
        cs_n_s[0] = 1'b1;
        rd_s[0]   = 1'b0;
        @(negedge clk);
        check_idle_zero(0, "rst_mid_access");
        rst = 1'b0;
        ctrl_read(0, 4'd5, 3, 16'hA5A5, 1'b0, 1'b0, 16'h0);

`ifdef MEM_PARITY_EN
        // Corrupt the stored parity bit of addr 2 and read it back.
        wr_word(0, 4'd2, 16'h0003);
        @(negedge clk);
        dut0.u_array.mem_q[2][16] = ~dut0.u_array.mem_q[2][16];
        ctrl_read(0, 4'd2, 3, 16'h0003, 1'b1, 1'b0, 16'h0);
        check("parity_out", {31'h0, par_w[0]}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
